// File: rtl/silly_function_pkg.sv
// Shared constants for the silly_function lookup block.
// Default truth table and hit counter width.
package silly_function_pkg;

    localparam logic [7:0] TT_DEFAULT    = 8'h31;
    localparam int         CNT_W_DEFAULT = 16;

    typedef logic [2:0] minterm_t;

endpackage

// File: rtl/silly_function_lut.sv
// Combinational three-input lookup.
// Index is {a,b,c} with a as MSB.
module silly_function_lut
    import silly_function_pkg::*;
#(
    parameter logic [7:0] TRUTH_TABLE = TT_DEFAULT
) (
    input  logic     a,
    input  logic     b,
    input  logic     c,
    output logic     y,
    output minterm_t minterm
);

    // Unknown inputs propagate through the index as-is.
    always_comb begin
        minterm = {a, b, c};
        y       = TRUTH_TABLE[minterm];
    end

endmodule

// File: rtl/silly_function.sv
// Lookup function with registered copy, edge pulses
// and a saturating hit counter.
module silly_function
    import silly_function_pkg::*;
#(
    parameter logic [7:0] TRUTH_TABLE = TT_DEFAULT,
    parameter int         CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             y,
    output logic             y_q,
    output logic             y_rise,
    output logic             y_fall,
    output logic [2:0]       minterm,
    output logic [CNT_W-1:0] hit_cnt
);

    logic cnt_sat;

    silly_function_lut #(
        .TRUTH_TABLE(TRUTH_TABLE)
    ) u_lut (
        .a      (a),
        .b      (b),
        .c      (c),
        .y      (y),
        .minterm(minterm)
    );

    assign cnt_sat = &hit_cnt;

    // Registered copy of y and its edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q    <= 1'b0;
            y_rise <= 1'b0;
            y_fall <= 1'b0;
        end else if (en) begin
            y_q    <= y;
            y_rise <= y & ~y_q;
            y_fall <= ~y & y_q;
        end else begin
            y_rise <= 1'b0;
            y_fall <= 1'b0;
        end
    end

    // Saturating count of enabled y=1 cycles; clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (clr) begin
            hit_cnt <= '0;
        end else if (en && y && !cnt_sat) begin
            hit_cnt <= hit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_silly_function.sv
// Directed self-checking bench for silly_function.
// A second instance uses a 4-bit counter for saturation.
module tb_silly_function;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        a;
    logic        b;
    logic        c;
    logic        y;
    logic        y_q;
    logic        y_rise;
    logic        y_fall;
    logic [2:0]  minterm;
    logic [15:0] hit_cnt;
    logic        s_y;
    logic        s_y_q;
    logic        s_y_rise;
    logic        s_y_fall;
    logic [2:0]  s_minterm;
    logic [3:0]  s_hit_cnt;

    int tests;
    int fails;

    silly_function dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .clr    (clr),
        .a      (a),
        .b      (b),
        .c      (c),
        .y      (y),
        .y_q    (y_q),
        .y_rise (y_rise),
        .y_fall (y_fall),
        .minterm(minterm),
        .hit_cnt(hit_cnt)
    );

    silly_function #(
        .CNT_W(4)
    ) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .clr    (clr),
        .a      (a),
        .b      (b),
        .c      (c),
        .y      (s_y),
        .y_q    (s_y_q),
        .y_rise (s_y_rise),
        .y_fall (s_y_fall),
        .minterm(s_minterm),
        .hit_cnt(s_hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("excl", 32'(y_rise & y_fall), 0);
    endtask

    task automatic set_abc(input logic [2:0] v);
        {a, b, c} = v;
        #1;
    endtask

    task automatic chk_regs(input string tag,
                            input logic eq,
                            input logic er,
                            input logic ef,
                            input int   eh);
        chk({tag, ".y_q"},  32'(y_q),    32'(eq));
        chk({tag, ".rise"}, 32'(y_rise), 32'(er));
        chk({tag, ".fall"}, 32'(y_fall), 32'(ef));
        chk({tag, ".hit"},  32'(hit_cnt), eh);
    endtask

    logic [7:0] exp_y;

    initial begin
        tests = 0;
        fails = 0;
        exp_y = 8'b0011_0001;
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        {a, b, c} = 3'b000;
        #2;

        for (int i = 0; i < 8; i++) begin
            set_abc(3'(i));
            chk($sformatf("sweep.y%0d", i), 32'(y), 32'(exp_y[i]));
            chk($sformatf("sweep.m%0d", i), 32'(minterm), i);
        end

        set_abc(3'b000);
        step();
        chk("rst.y", 32'(y), 1);
        chk_regs("rst", 1'b0, 1'b0, 1'b0, 0);
        chk("rst.hit4", 32'(s_hit_cnt), 0);

        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        step();
        chk_regs("rel1", 1'b1, 1'b1, 1'b0, 1);
        step();
        chk_regs("rel2", 1'b1, 1'b0, 1'b0, 2);

        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr0.hit", 32'(hit_cnt), 0);
        chk("clr0.hit4", 32'(s_hit_cnt), 0);

        set_abc(3'b100);
        for (int i = 0; i < 10; i++) step();
        chk_regs("cnt10", 1'b1, 1'b0, 1'b0, 10);
        chk("cnt10.hit4", 32'(s_hit_cnt), 10);

        set_abc(3'b010);
        chk("sw.y", 32'(y), 0);
        step();
        chk_regs("fall1", 1'b0, 1'b0, 1'b1, 10);
        step();
        chk_regs("fall2", 1'b0, 1'b0, 1'b0, 10);

        set_abc(3'b000);
        step();
        chk_regs("sat1", 1'b1, 1'b1, 1'b0, 11);
        for (int i = 0; i < 4; i++) step();
        chk("sat5.hit4", 32'(s_hit_cnt), 15);
        for (int i = 0; i < 15; i++) step();
        chk("sat20.hit4", 32'(s_hit_cnt), 15);
        chk("sat20.hit", 32'(hit_cnt), 30);

        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr1.hit", 32'(hit_cnt), 0);
        chk("clr1.hit4", 32'(s_hit_cnt), 0);

        for (int i = 0; i < 3; i++) step();
        chk_regs("pre_dis", 1'b1, 1'b0, 1'b0, 3);

        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_abc((i % 2 == 0) ? 3'b010 : 3'b000);
            step();
            chk_regs($sformatf("dis%0d", i), 1'b1, 1'b0, 1'b0, 3);
        end
        set_abc(3'b011);
        step();
        chk_regs("dis_y0", 1'b1, 1'b0, 1'b0, 3);
        chk("dis.y", 32'(y), 0);

        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_dis.hit", 32'(hit_cnt), 0);
        chk("clr_dis.y_q", 32'(y_q), 1);

        en = 1'b1;
        set_abc(3'b101);
        for (int i = 0; i < 4; i++) step();
        chk_regs("pre_rst", 1'b1, 1'b0, 1'b0, 4);

        #2;
        rst_n = 1'b0;
        #1;
        chk_regs("arst", 1'b0, 1'b0, 1'b0, 0);
        chk("arst.hit4", 32'(s_hit_cnt), 0);
        set_abc(3'b011);
        chk("arst.y0", 32'(y), 0);
        chk("arst.m3", 32'(minterm), 3);
        set_abc(3'b100);
        chk("arst.y1", 32'(y), 1);
        step();
        chk_regs("arst_edge", 1'b0, 1'b0, 1'b0, 0);

        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_regs("rerel", 1'b1, 1'b1, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
